// File: rtl/aes_round_sequencer_if.sv
// Handshake and datapath-control bundle between the AES inverse-cipher round
// sequencer, the software I/O side, the key-expansion unit and the shared datapath.
//   start        I/O -> seq   level job request, held high for the whole job
//   keyexp_done  KE  -> seq   all round keys valid (level)
//   keyexp_start seq -> KE    one-cycle key-expansion start pulse
//   op_sel       seq -> DP    0 NOP, 1 LOAD, 2 ADD_RK, 3 INV_SHIFT, 4 INV_SUB, 5 INV_MIX
//   state_we     seq -> DP    state register capture strobe
//   rk_idx       seq -> DP    round-key index for ADD_RK
//   col_sel      seq -> DP    column for INV_MIX
//   rnd          seq -> dbg   current round counter
//   busy/done    seq -> I/O   job status
// The master modport is the sequencer; the slave modport is its environment.
interface aes_round_sequencer_if;
   logic       start;
   logic       keyexp_done;
   logic       keyexp_start;
   logic [2:0] op_sel;
   logic       state_we;
   logic [3:0] rk_idx;
   logic [1:0] col_sel;
   logic [3:0] rnd;
   logic       busy;
   logic       done;

   modport master (
      input  start, keyexp_done,
      output keyexp_start, op_sel, state_we, rk_idx, col_sel, rnd, busy, done
   );

   modport slave (
      output start, keyexp_done,
      input  keyexp_start, op_sel, state_we, rk_idx, col_sel, rnd, busy, done
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for the shared AES-128 inverse-cipher datapath. Kicks off key
// expansion, then issues one datapath op per cycle (LOAD, ADD_RK, INV_SHIFT,
// INV_SUB, INV_MIX per column) with write strobe, round-key index and column select.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    aes_round_sequencer_if.master (handshake + datapath control)
// All outputs decode from registered state/counters only.
module aes_round_sequencer #(
   parameter int unsigned NR      = 10,
   parameter int unsigned SUB_LAT = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   aes_round_sequencer_if.master        bus
);

   typedef enum logic [2:0] {
      StIdle, StKeyexp, StLoad, StArk, StIsr, StIsb, StImc, StDone
   } state_e;

   localparam logic [2:0] OpNop      = 3'd0;
   localparam logic [2:0] OpLoad     = 3'd1;
   localparam logic [2:0] OpAddRk    = 3'd2;
   localparam logic [2:0] OpInvShift = 3'd3;
   localparam logic [2:0] OpInvSub   = 3'd4;
   localparam logic [2:0] OpInvMix   = 3'd5;

   localparam logic [3:0] RndFirst = 4'(NR);
   localparam logic [1:0] SubLast  = 2'(SUB_LAT - 1);

   state_e     state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   // Shared counter: KEYEXP first-cycle marker, ISB latency count, IMC column.
   logic [1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rnd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (bus.start) state_d = StKeyexp;
         end
         StKeyexp: begin
            // cnt_q==0 marks the pulse cycle; keyexp_done is honoured only after it.
            cnt_d = 2'd1;
            if (cnt_q != 2'd0 && bus.keyexp_done) state_d = StLoad;
         end
         StLoad: begin
            rnd_d   = RndFirst;
            state_d = StArk;
         end
         StArk: begin
            if (rnd_q == RndFirst) begin
               rnd_d   = rnd_q - 4'd1;
               state_d = StIsr;
            end else if (rnd_q == 4'd0) begin
               state_d = StDone;
            end else begin
               cnt_d   = '0;
               state_d = StImc;
            end
         end
         StIsr: begin
            cnt_d   = '0;
            state_d = StIsb;
         end
         StIsb: begin
            if (cnt_q == SubLast) state_d = StArk;
            else                  cnt_d   = cnt_q + 2'd1;
         end
         StImc: begin
            if (cnt_q == 2'd3) begin
               cnt_d   = '0;
               rnd_d   = rnd_q - 4'd1;
               state_d = StIsr;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StDone: begin
            if (!bus.start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort: a dropped request mid-job returns to IDLE without further writes.
      if (!bus.start && state_q inside {StKeyexp, StLoad, StArk, StIsr, StIsb, StImc}) begin
         state_d = StIdle;
         rnd_d   = '0;
         cnt_d   = '0;
      end
   end

   always_comb begin
      bus.keyexp_start = 1'b0;
      bus.op_sel       = OpNop;
      bus.state_we     = 1'b0;
      bus.col_sel      = 2'd0;
      bus.rk_idx       = rnd_q;
      bus.rnd          = rnd_q;
      bus.busy         = 1'b1;
      bus.done         = 1'b0;
      unique case (state_q)
         StIdle:   bus.busy = 1'b0;
         StKeyexp: bus.keyexp_start = (cnt_q == 2'd0);
         StLoad: begin
            bus.op_sel   = OpLoad;
            bus.state_we = 1'b1;
         end
         StArk: begin
            bus.op_sel   = OpAddRk;
            bus.state_we = 1'b1;
         end
         StIsr: begin
            bus.op_sel   = OpInvShift;
            bus.state_we = 1'b1;
         end
         StIsb: begin
            bus.op_sel   = OpInvSub;
            bus.state_we = (cnt_q == SubLast);
         end
         StImc: begin
            bus.op_sel   = OpInvMix;
            bus.state_we = 1'b1;
            bus.col_sel  = cnt_q;
         end
         StDone: begin
            bus.busy = 1'b0;
            bus.done = 1'b1;
         end
         default: bus.busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (SUB_LAT=1 and SUB_LAT=3) share
// clock and reset. A job-level model (idle / key expansion / op trace / done)
// with the op trace built from the round rules predicts every output each cycle.
module tb_aes_round_sequencer;
   localparam int NR    = 10;
   localparam int MIdle = 0;
   localparam int MKx   = 1;
   localparam int MRun  = 2;
   localparam int MDone = 3;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic hold0  = 1'b0, hold1  = 1'b0;
   logic arm0   = 1'b0, arm1   = 1'b0;
   int   kdel0  = 5,    kdel1  = 5;

   always #5 clk = ~clk;

   aes_round_sequencer_if bus0 ();
   aes_round_sequencer_if bus1 ();

   assign bus0.start       = start0;
   assign bus0.keyexp_done = hold0 | arm0;
   assign bus1.start       = start1;
   assign bus1.keyexp_done = hold1 | arm1;

   aes_round_sequencer #(.NR(NR), .SUB_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus0));
   aes_round_sequencer #(.NR(NR), .SUB_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus1));

   // Key-expansion responders: keyexp_done rises kdel cycles after the pulse.
   initial begin
      int k = 0;
      forever begin
         @(posedge clk); #1;
         if (!start0) begin arm0 = 1'b0; k = 0; end
         else if (bus0.keyexp_start) begin arm0 = 1'b0; k = kdel0; end
         else if (k > 0) begin k--; if (k == 0) arm0 = 1'b1; end
      end
   end
   initial begin
      int k = 0;
      forever begin
         @(posedge clk); #1;
         if (!start1) begin arm1 = 1'b0; k = 0; end
         else if (bus1.keyexp_start) begin arm1 = 1'b0; k = kdel1; end
         else if (k > 0) begin k--; if (k == 0) arm1 = 1'b1; end
      end
   end

   // ---------------- model and checker ----------------
   int t_op [2][0:127];
   int t_we [2][0:127];
   int t_col[2][0:127];
   int t_rnd[2][0:127];
   int t_len[2];
   int m_mode[2], m_kx[2], m_pos[2];
   bit m_known[2];
   int load_cyc[2], kx_cyc[2], we_cnt[2], ark_cnt[2], ks_cnt[2];
   bit kd_entry[2], prev_done[2];
   int n_chk = 0, n_pass = 0, cyc = 0, to_cnt = 0, to_seen = 0;
   bit rst_prev = 1'b0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
   endtask

   task automatic push(input int ch, input int op, input int we, input int col, input int rn);
      t_op[ch][t_len[ch]]  = op;
      t_we[ch][t_len[ch]]  = we;
      t_col[ch][t_len[ch]] = col;
      t_rnd[ch][t_len[ch]] = rn;
      t_len[ch]++;
   endtask

   // Op trace from LOAD to the final ADD_RK; rnd -1 means not checked.
   task automatic build(input int ch, input int s);
      t_len[ch] = 0;
      push(ch, 1, 1, 0, -1);
      push(ch, 2, 1, 0, NR);
      for (int r = NR - 1; r >= 0; r--) begin
         push(ch, 3, 1, 0, r);
         for (int i = 0; i < s; i++) push(ch, 4, (i == s - 1) ? 1 : 0, 0, r);
         push(ch, 2, 1, 0, r);
         if (r > 0) for (int c = 0; c < 4; c++) push(ch, 5, 1, c, r);
      end
   endtask

   task automatic cmp_ch(input int ch, input int ks, input int op, input int we, input int rk,
                         input int col, input int rn, input int busy, input int dn,
                         input int r, input int s, input int k);
      int    e_op = 0, e_we = 0, e_col = 0, e_busy = 0, e_done = 0, e_ks = 0, e_rn = -1;
      string p = (ch == 0) ? "s1" : "s3";
      case (m_mode[ch])
         MIdle: if (m_known[ch]) e_rn = 0;
         MKx: begin
            e_busy = 1;
            e_ks   = (m_kx[ch] == 0) ? 1 : 0;
            if (m_kx[ch] == 0) begin
               kx_cyc[ch] = cyc; kd_entry[ch] = (k != 0); ks_cnt[ch] = 0;
            end
         end
         MRun: begin
            e_busy = 1;
            e_op   = t_op[ch][m_pos[ch]];
            e_we   = t_we[ch][m_pos[ch]];
            e_col  = t_col[ch][m_pos[ch]];
            e_rn   = t_rnd[ch][m_pos[ch]];
            if (m_pos[ch] == 0) begin
               load_cyc[ch] = cyc; we_cnt[ch] = 0; ark_cnt[ch] = 0;
               if (kd_entry[ch]) chk({p, "_heldkd_load_gap"}, cyc - kx_cyc[ch], 2);
            end
         end
         default: begin e_done = 1; e_rn = 0; end
      endcase
      chk({p, "_op"}, op, e_op);
      chk({p, "_we"}, we, e_we);
      chk({p, "_col"}, col, e_col);
      chk({p, "_busy"}, busy, e_busy);
      chk({p, "_done"}, dn, e_done);
      chk({p, "_kxstart"}, ks, e_ks);
      if (e_rn >= 0) begin
         chk({p, "_rnd"}, rn, e_rn);
         chk({p, "_rkidx"}, rk, e_rn);
      end
      if (m_mode[ch] == MRun) begin
         we_cnt[ch]  += we;
         ark_cnt[ch] += (op == 2) ? 1 : 0;
      end
      ks_cnt[ch] += ks;
      if (m_mode[ch] == MDone && !prev_done[ch]) begin
         chk({p, "_latency"}, cyc - load_cyc[ch], (ch == 0) ? 68 : 88);
         chk({p, "_we_count"}, we_cnt[ch], 68);
         chk({p, "_ark_count"}, ark_cnt[ch], 11);
         chk({p, "_kxstart_pulses"}, ks_cnt[ch], 1);
      end
      prev_done[ch] = (m_mode[ch] == MDone);

      // Advance on the inputs the next rising edge will sample.
      if (r != 0) begin
         m_mode[ch] = MIdle; m_known[ch] = 1'b1;
      end else begin
         case (m_mode[ch])
            MIdle: if (s != 0) begin m_mode[ch] = MKx; m_kx[ch] = 0; end
            MKx: begin
               if (s == 0) begin m_mode[ch] = MIdle; m_known[ch] = 1'b0; end
               else if (m_kx[ch] >= 1 && k != 0) begin m_mode[ch] = MRun; m_pos[ch] = 0; end
               else m_kx[ch] = 1;
            end
            MRun: begin
               if (s == 0) begin m_mode[ch] = MIdle; m_known[ch] = 1'b0; end
               else begin
                  m_pos[ch]++;
                  if (m_pos[ch] == t_len[ch]) m_mode[ch] = MDone;
               end
            end
            default: if (s == 0) begin m_mode[ch] = MIdle; m_known[ch] = 1'b1; end
         endcase
      end
   endtask

   initial begin
      for (int c = 0; c < 2; c++) begin
         m_mode[c] = MIdle; m_kx[c] = 0; m_pos[c] = 0; m_known[c] = 1'b1; prev_done[c] = 1'b0;
      end
      build(0, 1);
      build(1, 3);
      // Hand-computed pins on the model's own trace.
      chk("model_len_s1", t_len[0], 68);
      chk("model_len_s3", t_len[1], 88);
      chk("model_ark10_rk", t_rnd[0][1], 10);
      chk("model_last_op", t_op[0][67], 2);
      chk("model_last_rk", t_rnd[0][67], 0);
      chk("model_s3_isb_we", t_we[1][3] + 2 * t_we[1][4] + 4 * t_we[1][5], 4);
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_prev) begin
            chk("reset_all_zero", bus0.op_sel | bus0.state_we | bus0.busy | bus0.done |
                bus0.rnd | bus0.rk_idx | bus0.col_sel | bus0.keyexp_start, 0);
         end
         cmp_ch(0, bus0.keyexp_start, bus0.op_sel, bus0.state_we, bus0.rk_idx, bus0.col_sel,
                bus0.rnd, bus0.busy, bus0.done, reset, start0, bus0.keyexp_done);
         cmp_ch(1, bus1.keyexp_start, bus1.op_sel, bus1.state_we, bus1.rk_idx, bus1.col_sel,
                bus1.rnd, bus1.busy, bus1.done, reset, start1, bus1.keyexp_done);
         if (to_cnt != to_seen) begin
            chk("wait_timeout", to_cnt, to_seen);
            to_seen = to_cnt;
         end
         rst_prev = reset;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic wait_for(input int kind, input int bound);
      bit hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         tick();
         case (kind)
            0: hit = bus0.done;
            1: hit = bus1.done;
            2: hit = (bus0.op_sel == 3'd5 && bus0.rnd == 4'd5 && bus0.col_sel == 2'd2);
            3: hit = (bus0.op_sel == 3'd4 && bus0.rnd == 4'd3);
            default: hit = 1'b1;
         endcase
      end
      if (!hit) to_cnt++;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();
      // Nominal run plus 20-cycle done hold.
      start0 = 1'b1;
      wait_for(0, 200);
      repeat (20) tick();
      start0 = 1'b0;
      repeat (3) tick();
      // Identical rerun.
      start0 = 1'b1;
      wait_for(0, 200);
      start0 = 1'b0;
      repeat (3) tick();
      // Abort at rnd 5, column 2, then restart.
      start0 = 1'b1;
      wait_for(2, 200);
      start0 = 1'b0;
      repeat (5) tick();
      start0 = 1'b1;
      wait_for(0, 200);
      start0 = 1'b0;
      repeat (3) tick();
      // Reset during ISB at rnd 3.
      start0 = 1'b1;
      wait_for(3, 200);
      reset = 1'b1;
      repeat (3) tick();
      start0 = 1'b0;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      // SUB_LAT=3 instance.
      start1 = 1'b1;
      wait_for(1, 300);
      start1 = 1'b0;
      repeat (3) tick();
      // keyexp_done already high before start.
      hold0 = 1'b1;
      tick();
      start0 = 1'b1;
      wait_for(0, 200);
      start0 = 1'b0;
      tick();
      hold0 = 1'b0;
      repeat (2) tick();
      // Randomised jobs: random key-expansion delay, abort point and idle gap.
      for (int j = 0; j < 8; j++) begin
         kdel0  = int'($urandom_range(1, 8));
         kdel1  = int'($urandom_range(1, 8));
         start0 = 1'b1;
         start1 = 1'b1;
         repeat ($urandom_range(3, 110)) tick();
         start0 = 1'b0;
         repeat ($urandom_range(0, 20)) tick();
         start1 = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
      end
      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
